// File: rtl/fifo_rd_unpacker.sv
// rtl/fifo_rd_unpacker.sv - drains wide show-ahead FIFO words into narrow valid/ready beats
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   o_fifo_rden    FIFO pop strobe (combinational)
//   i_fifo_rddata  FIFO head word, valid when !i_fifo_empty
//   i_fifo_empty   FIFO empty flag
//   i_flush        drop the remaining beats of the held word
//   o_valid        output beat valid
//   o_data         output beat
//   o_last         final beat of the current word
//   i_ready        consumer ready
//   o_busy         a word is held
//
// Build option: define UNPACK_MSB_FIRST_EN to emit the most significant slice first.

module fifo_rd_unpacker #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_fifo_rden,
    input  logic [IN_W-1:0]  i_fifo_rddata,
    input  logic             i_fifo_empty,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_last,
    input  logic             i_ready,
    output logic             o_busy
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int BW    = $clog2(RATIO);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_rg;
    state_t            state_nx;
    logic [IN_W-1:0]   hold_rg;
    logic [BW-1:0]     beat_rg;
    logic              load;
    logic              beat_last;
    logic              beat_adv;
    logic [IN_W-1:0]   shifted;
    int                slice_idx;

    assign beat_last = (beat_rg == BW'(RATIO - 1));

    // Non-last beat handed over; flush wins over a simultaneous accept.
    assign beat_adv = (state_rg == DRAIN) && !i_flush && i_ready && !beat_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_rg <= IDLE;
        end else begin
            state_rg <= state_nx;
        end
    end

    // Next state, plus the load decision that both the pop strobe and the
    // hold register depend on.
    always_comb begin
        state_nx = state_rg;
        load     = 1'b0;
        case (state_rg)
            IDLE: begin
                if (!i_fifo_empty) begin
                    load     = 1'b1;
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (i_flush) begin
                    state_nx = IDLE;
                end else if (i_ready && beat_last) begin
                    if (!i_fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_rg <= '0;
            beat_rg <= '0;
        end else if (load) begin
            hold_rg <= i_fifo_rddata;
            beat_rg <= '0;
        end else if (beat_adv) begin
            beat_rg <= beat_rg + BW'(1);
        end
    end

    // Beat selection as a right shift keeps the index arithmetic in int.
    always_comb begin
`ifdef UNPACK_MSB_FIRST_EN
        slice_idx = RATIO - 1 - int'(beat_rg);
`else
        slice_idx = int'(beat_rg);
`endif
        shifted = hold_rg >> (slice_idx * OUT_W);
    end

    // Outputs depend only on registered state except the pop strobe, which
    // must be combinational so the FIFO advances on the reload edge.
    always_comb begin
        o_valid     = (state_rg == DRAIN);
        o_busy      = (state_rg == DRAIN);
        o_last      = (state_rg == DRAIN) && beat_last;
        o_data      = (state_rg == DRAIN) ? shifted[OUT_W-1:0] : '0;
        o_fifo_rden = load && !rst;
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// tb/tb_fifo_rd_unpacker.sv - scoreboard bench for fifo_rd_unpacker

module tb_fifo_rd_unpacker;

    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int RATIO = IN_W / OUT_W;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             l;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             o_fifo_rden;
    logic [IN_W-1:0]  i_fifo_rddata = '0;
    logic             i_fifo_empty = 1'b1;
    logic             i_flush = 1'b0;
    logic             o_valid;
    logic [OUT_W-1:0] o_data;
    logic             o_last;
    logic             i_ready = 1'b0;
    logic             o_busy;

    always #5 clk = ~clk;

    fifo_rd_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_fifo_rden   (o_fifo_rden),
        .i_fifo_rddata (i_fifo_rddata),
        .i_fifo_empty  (i_fifo_empty),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_busy        (o_busy)
    );

    logic [IN_W-1:0] fifo_q[$];
    beat_t           exp_q[$];
    int              rem = 0;
    int              n_chk = 0;
    int              n_fail = 0;
    bit              pop_pending = 0;
    bit              mon_en = 0;
    int              ready_pct = 100;
    int              flush_pct = 0;
    int              present_pct = 100;
    bit              prev_stall = 0;
    logic [OUT_W-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat k of word w from the slice-order rule.
    function automatic beat_t mk_beat(input logic [IN_W-1:0] w, input int k);
        beat_t b;
        int idx;
`ifdef UNPACK_MSB_FIRST_EN
        idx = RATIO - 1 - k;
`else
        idx = k;
`endif
        b.d = w[idx*OUT_W +: OUT_W];
        b.l = (k == RATIO - 1);
        return b;
    endfunction

    function automatic logic [IN_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Input driver: performs pops decided on the previous cycle, then
    // presents new random handshake inputs shortly after the edge.
    always @(posedge clk) begin
        bit present;
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pending = 0;
        i_ready = ($urandom_range(99) < ready_pct);
        i_flush = ($urandom_range(99) < flush_pct);
        present = ($urandom_range(99) < present_pct);
        i_fifo_empty = !(present && fifo_q.size() > 0);
        i_fifo_rddata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        bit exp_rden;
        beat_t b;
        if (mon_en && !rst) begin
            exp_rden = !i_fifo_empty && (rem == 0 || (rem == 1 && i_ready && !i_flush));
            check("rden", o_fifo_rden, exp_rden);
            check("valid", o_valid, rem > 0);
            check("busy", o_busy, rem > 0);
            if (prev_stall) begin
                check("stall_data", o_data, prev_data);
                check("stall_last", o_last, prev_last);
            end
            if (o_valid && i_ready && !i_flush) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", o_data, b.d);
                    check("beat_last", o_last, b.l);
                end
            end
            prev_stall = o_valid && !i_ready && !i_flush;
            prev_data  = o_data;
            prev_last  = o_last;

            if (i_flush && rem > 0) begin
                exp_q.delete();
                rem = 0;
            end else if (rem > 0 && i_ready) begin
                rem--;
            end
            if (exp_rden) begin
                for (int k = 0; k < RATIO; k++) exp_q.push_back(mk_beat(fifo_q[0], k));
                rem = RATIO;
                pop_pending = 1;
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic wait_drained(input string name, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (!(fifo_q.size() == 0 && rem == 0 && !o_valid) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) check({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int run;
        int n;
        logic [IN_W-1:0] w0;

        // Reset state while a word is already waiting.
        w0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        fifo_q.push_back(w0);
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rden", o_fifo_rden, 0);
        check("rst_data", o_data, 0);

        // Single known word, consumer always ready.
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1;
        wait_drained("single", 50);
        repeat (2) @(negedge clk);
        check("single_idle_busy", o_busy, 0);

        // Three words back-to-back: twelve valid cycles with no gap.
        for (int i = 0; i < 3; i++) fifo_q.push_back(rand_word());
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        while (o_valid && run < 40) begin
            run++;
            @(negedge clk);
        end
        check("b2b_valid_run", run, 3 * RATIO);
        wait_drained("b2b", 50);

        // Random backpressure, flushes and FIFO empty toggling.
        ready_pct = 60;
        flush_pct = 8;
        present_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (fifo_q.size() < 3 && $urandom_range(3) == 0) fifo_q.push_back(rand_word());
        end
        flush_pct = 0;
        ready_pct = 100;
        present_pct = 100;
        wait_drained("random", 200);

        // Asynchronous reset in the middle of a word.
        fifo_q.push_back(rand_word());
        fifo_q.push_back(rand_word());
        ready_pct = 100;
        n = 0;
        @(negedge clk);
        while (!(o_valid && rem == RATIO - 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reach", rem, RATIO - 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        rem = 0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_last", o_last, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_rden", o_fifo_rden, 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_rden_hold", o_fifo_rden, 0);
        end
        check("mid_rst_fifo_kept", fifo_q.size(), 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_drained("post_rst", 50);
        check("post_rst_exp_empty", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
